fu_alu_pipe: RTL

FU_ALU_PIPE -- requirements
Module: fu_alu_pipe

---
 rtl/fu_alu_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit with LAT valid/ready stages, flush and tag return.
// Define FU_ALU_MINMAX_EN to add the MIN/MAX/MINU op codes (13..15).
module fu_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             busy,
    output logic [2:0]       occupancy
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3, OP_OR   = 4'h4,
        OP_XOR  = 4'h5, OP_SLL  = 4'h6, OP_SRL  = 4'h7, OP_SLT  = 4'h8,
        OP_SLTU = 4'h9, OP_SRA  = 4'hA, OP_ADD4 = 4'hB, OP_PASSB = 4'hC,
        OP_MIN  = 4'hD, OP_MAX  = 4'hE, OP_MINU = 4'hF
    } op_e;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic [SHW-1:0]   shamt;
    logic             alu_ovf;

    always_comb begin
        sum     = in_a + in_b;
        diff    = in_a - in_b;
        shamt   = in_b[SHW-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_e'(in_op))
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:   alu_res = in_a & in_b;
            OP_OR:    alu_res = in_a | in_b;
            OP_XOR:   alu_res = in_a ^ in_b;
            OP_SLL:   alu_res = in_a << shamt;
            OP_SRL:   alu_res = in_a >> shamt;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
            OP_SRA:   alu_res = $signed(in_a) >>> shamt;
            OP_ADD4:  alu_res = in_a + WIDTH'(4);
            OP_PASSB: alu_res = in_b;
`ifdef FU_ALU_MINMAX_EN
            OP_MIN:   alu_res = ($signed(in_a) < $signed(in_b)) ? in_a : in_b;
            OP_MAX:   alu_res = ($signed(in_a) < $signed(in_b)) ? in_b : in_a;
            OP_MINU:  alu_res = (in_a < in_b) ? in_a : in_b;
`endif
            default:  alu_res = '0;
        endcase
    end

    logic             v_q   [LAT];
    logic             v_d   [LAT];
    logic [WIDTH-1:0] res_q [LAT];
    logic [WIDTH-1:0] res_d [LAT];
    logic             ovf_q [LAT];
    logic             ovf_d [LAT];
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic             adv   [LAT];
    logic             hole;

    // A stage can advance iff some stage at or after it is empty, or the
    // output is being consumed; computed as a running OR from the tail.
    always_comb begin
        // NOTE: blocking '=' in combinational logic so 'hole' accumulates in order.
        hole = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            hole   = hole || !v_q[k];
            adv[k] = hole;
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            v_d[k]   = v_q[k];
            res_d[k] = res_q[k];
            ovf_d[k] = ovf_q[k];
            tag_d[k] = tag_q[k];
        end
        if (flush) begin
            // Kill everything in flight; data registers keep their contents.
            for (int k = 0; k < LAT; k++) v_d[k] = 1'b0;
        end else begin
            if (adv[0]) begin
                v_d[0]   = in_valid;
                res_d[0] = alu_res;
                ovf_d[0] = alu_ovf;
                tag_d[0] = in_tag;
            end
            for (int k = 1; k < LAT; k++) begin
                if (adv[k]) begin
                    v_d[k]   = v_q[k-1];
                    res_d[k] = res_q[k-1];
                    ovf_d[k] = ovf_q[k-1];
                    tag_d[k] = tag_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage arrays are flop banks, not RAM, so resetting them is legal and cheap.
            for (int k = 0; k < LAT; k++) begin
                v_q[k]   <= 1'b0;
                res_q[k] <= '0;
                ovf_q[k] <= 1'b0;
                tag_q[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses '<=' so all stages shift from pre-edge values.
            for (int k = 0; k < LAT; k++) begin
                v_q[k]   <= v_d[k];
                res_q[k] <= res_d[k];
                ovf_q[k] <= ovf_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < LAT; k++) occupancy = occupancy + {2'b00, v_q[k]};
    end

    assign busy      = (occupancy != 3'd0);
    assign out_valid = v_q[LAT-1];
    assign out_res   = res_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign out_ovf   = ovf_q[LAT-1];
    assign out_zero  = ~|res_q[LAT-1];

endmodule
